// File: rtl/dmem_lsu.sv
// dmem_lsu: data-memory load/store unit with an internal byte-addressed,
// word-organised RAM. Loads return one cycle after the request and may cross a
// word boundary at no extra cost because two adjacent words are read together.
// Stores are sequenced by a small FSM. A store that crosses a word boundary
// takes a second write cycle.
//
// Ports:
//   clk_i           clock, rising edge
//   rstn_i          asynchronous active-low reset
//   addr_i          byte address; upper bits alias modulo the RAM size
//   wdata_i         store data, right-aligned
//   mem_r_en_i      load request pulse
//   mem_r_sext_i    sign-extend sub-word load
//   mem_acc_r_i     load size: 0 byte, 1 half, 2 word, 3 reserved (reads 0)
//   mem_wr_en_i     store request pulse (ignored while busy_o)
//   mem_acc_w_i     store size, same encoding (3 writes nothing)
//   mem_wr_ready_o  high in the cycle the final RAM write of a store commits
//   rdata_o         aligned, extended load result, held until the next load
//   busy_o          store in progress
module dmem_lsu #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_r_en_i,
    input  logic        mem_r_sext_i,
    input  logic [1:0]  mem_acc_r_i,
    input  logic        mem_wr_en_i,
    input  logic [1:0]  mem_acc_w_i,
    output logic        mem_wr_ready_o,
    output logic [31:0] rdata_o,
    output logic        busy_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WR1, ST_WR2} state_e;

    logic [31:0] mem [DEPTH_WORDS];

    // Request address decode; idx1 wraps modulo the RAM size.
    logic [AW-1:0] req_idx0;
    logic [AW-1:0] req_idx1;
    logic [1:0]    req_off;
    logic          unused_addr;

    assign req_idx0    = addr_i[AW+1:2];
    assign req_idx1    = req_idx0 + AW'(1);
    assign req_off     = addr_i[1:0];
    assign unused_addr = ^addr_i[31:AW+2];

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] ld_lo_q;
    logic [31:0] ld_hi_q;
    logic [1:0]  ld_off_q;
    logic [1:0]  ld_size_q;
    logic        ld_sext_q;
    logic [31:0] ld_shift;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ld_lo_q   <= '0;
            ld_hi_q   <= '0;
            ld_off_q  <= '0;
            ld_size_q <= '0;
            ld_sext_q <= 1'b0;
        end else if (mem_r_en_i) begin
            ld_lo_q   <= mem[req_idx0];
            ld_hi_q   <= mem[req_idx1];
            ld_off_q  <= req_off;
            ld_size_q <= mem_acc_r_i;
            ld_sext_q <= mem_r_sext_i;
        end
    end

    assign ld_shift = 32'({ld_hi_q, ld_lo_q} >> {ld_off_q, 3'b000});

    always_comb begin
        rdata_o = '0;
        unique case (ld_size_q)
            2'd0:    rdata_o = {{24{ld_sext_q & ld_shift[7]}}, ld_shift[7:0]};
            2'd1:    rdata_o = {{16{ld_sext_q & ld_shift[15]}}, ld_shift[15:0]};
            2'd2:    rdata_o = ld_shift;
            default: rdata_o = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store FSM
    // ------------------------------------------------------------------
    state_e        state_q;
    logic          ready_q;
    logic [AW-1:0] st_idx_q;
    logic [1:0]    st_off_q;
    logic [1:0]    st_size_q;
    logic [31:0]   st_data_q;
    logic          st_split_q;
    logic          req_split;

    assign req_split = (mem_acc_w_i == 2'd1 && req_off == 2'd3) ||
                       (mem_acc_w_i == 2'd2 && req_off != 2'd0);

    // ready_q is set on entry to the state whose write is the final one, so it
    // is high exactly during that state and never depends on live inputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            st_idx_q   <= '0;
            st_off_q   <= '0;
            st_size_q  <= '0;
            st_data_q  <= '0;
            st_split_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (mem_wr_en_i) begin
                        st_idx_q   <= req_idx0;
                        st_off_q   <= req_off;
                        st_size_q  <= mem_acc_w_i;
                        st_data_q  <= wdata_i;
                        st_split_q <= req_split;
                        ready_q    <= !req_split;
                        state_q    <= ST_WR1;
                    end
                end
                ST_WR1: begin
                    if (st_split_q) begin
                        ready_q <= 1'b1;
                        state_q <= ST_WR2;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WR2:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_wr_ready_o = ready_q;
    assign busy_o         = (state_q != ST_IDLE);

    // Byte lanes of the store spread over two words: low nibble of st_be and
    // low half of st_wide go to idx0, the upper parts to idx0+1.
    logic [3:0]  st_mask;
    logic [7:0]  st_be;
    logic [63:0] st_wide;

    always_comb begin
        st_mask = 4'b0000;
        unique case (st_size_q)
            2'd0:    st_mask = 4'b0001;
            2'd1:    st_mask = 4'b0011;
            2'd2:    st_mask = 4'b1111;
            default: st_mask = 4'b0000;
        endcase
    end

    assign st_be   = {4'b0000, st_mask} << st_off_q;
    assign st_wide = {32'h0, st_data_q} << {st_off_q, 3'b000};

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = st_idx_q;
        wr_be   = '0;
        wr_data = '0;
        unique case (state_q)
            ST_WR1: begin
                wr_en   = 1'b1;
                wr_be   = st_be[3:0];
                wr_data = st_wide[31:0];
            end
            ST_WR2: begin
                wr_en   = 1'b1;
                wr_idx  = st_idx_q + AW'(1);
                wr_be   = st_be[7:4];
                wr_data = st_wide[63:32];
            end
            default: ;
        endcase
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized
// load/store traffic checked against a byte-array reference memory.
module tb_dmem_lsu;

    localparam int MEM_BYTES = 4096;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_r_en_i;
    logic        mem_r_sext_i;
    logic [1:0]  mem_acc_r_i;
    logic        mem_wr_en_i;
    logic [1:0]  mem_acc_w_i;
    logic        mem_wr_ready_o;
    logic [31:0] rdata_o;
    logic        busy_o;

    dmem_lsu #(.DEPTH_WORDS(1024)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .mem_r_en_i     (mem_r_en_i),
        .mem_r_sext_i   (mem_r_sext_i),
        .mem_acc_r_i    (mem_acc_r_i),
        .mem_wr_en_i    (mem_wr_en_i),
        .mem_acc_w_i    (mem_acc_w_i),
        .mem_wr_ready_o (mem_wr_ready_o),
        .rdata_o        (rdata_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [MEM_BYTES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic sx);
        logic [31:0] v;
        int n;
        v = '0;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[12'(a + 32'(i))];
        if (sx && n > 0 && n < 4 && v[8*n-1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] sz);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[12'(a + 32'(i))] = d[8*i +: 8];
    endfunction

    task automatic do_load_exp(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                               input logic [31:0] exp, input string tag);
        addr_i       = a;
        mem_acc_r_i  = sz;
        mem_r_sext_i = sx;
        mem_r_en_i   = 1'b1;
        tick();
        mem_r_en_i   = 1'b0;
        addr_i       = $urandom();
        mem_acc_r_i  = 2'($urandom_range(0, 3));
        check(tag, rdata_o, exp);
        tick();
        check({tag, ".hold"}, rdata_o, exp);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                           input string tag);
        do_load_exp(a, sz, sx, model_load(a, sz, sx), tag);
    endtask

    // Store, optionally with a load to the same address in the same cycle, and
    // optionally hammering mem_wr_en_i while busy (must be ignored).
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input logic with_ld, input logic [1:0] lsz, input logic lsx,
                            input logic junk, input string tag);
        int n;
        int lat;
        logic [31:0] ld_exp;
        n      = nbytes(sz);
        lat    = (n != 0 && int'(a[1:0]) + n > 4) ? 2 : 1;
        ld_exp = model_load(a, lsz, lsx);
        addr_i       = a;
        wdata_i      = d;
        mem_acc_w_i  = sz;
        mem_wr_en_i  = 1'b1;
        mem_r_en_i   = with_ld;
        mem_acc_r_i  = lsz;
        mem_r_sext_i = lsx;
        tick();
        mem_r_en_i   = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            mem_wr_en_i = junk;
            wdata_i     = $urandom();
            if (with_ld && c == 1) check({tag, ".ld"}, rdata_o, ld_exp);
            check({tag, ".busy"}, 32'(busy_o), 32'd1);
            check({tag, ".rdy"}, 32'(mem_wr_ready_o), 32'(c == lat));
            tick();
        end
        mem_wr_en_i = 1'b0;
        check({tag, ".idle"}, 32'(busy_o), 32'd0);
        check({tag, ".rdy0"}, 32'(mem_wr_ready_o), 32'd0);
        model_store(a, d, sz);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input string tag);
        do_store(a, d, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [31:0] a;
        int widx;
        int op;

        rstn_i       = 1'b0;
        addr_i       = '0;
        wdata_i      = '0;
        mem_r_en_i   = 1'b0;
        mem_r_sext_i = 1'b0;
        mem_acc_r_i  = '0;
        mem_wr_en_i  = 1'b0;
        mem_acc_w_i  = '0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst.rdata", rdata_o, 32'h0);
        check("rst.busy", 32'(busy_o), 32'd0);
        check("rst.ready", 32'(mem_wr_ready_o), 32'd0);
        rstn_i = 1'b1;
        tick();

        // Initialise the words the random phase touches.
        for (int w = 0; w < 16; w++) sw(32'(w) << 2, $urandom(), "init");
        for (int w = 1008; w < 1024; w++) sw(32'(w) << 2, $urandom(), "init");

        // Aligned word.
        sw(32'h10, 32'hDEADBEEF, "sw_al");
        do_load_exp(32'h10, 2'd2, 1'b0, 32'hDEADBEEF, "lw_al");

        // Sub-word extension.
        sw(32'h10, 32'h8081F0F1, "sw_ext");
        do_load_exp(32'h12, 2'd0, 1'b1, 32'hFFFFFF81, "lb");
        do_load_exp(32'h12, 2'd0, 1'b0, 32'h00000081, "lbu");
        do_load_exp(32'h10, 2'd1, 1'b1, 32'hFFFFF0F1, "lh");
        do_load_exp(32'h12, 2'd1, 1'b0, 32'h00008081, "lhu");

        // Crossing store and load.
        sw(32'h0, 32'h0, "z0");
        sw(32'h4, 32'h0, "z1");
        sw(32'h8, 32'h0, "z2");
        sw(32'h3, 32'h11223344, "sw_x");
        do_load_exp(32'h0, 2'd2, 1'b0, 32'h44000000, "x.w0");
        do_load_exp(32'h4, 2'd2, 1'b0, 32'h00112233, "x.w1");
        do_load_exp(32'h3, 2'd2, 1'b0, 32'h11223344, "lw_x");
        do_load_exp(32'h7, 2'd1, 1'b1, 32'h00000000, "lh_x");
        do_store(32'h7, 32'h0000ABCD, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, "sh_x");
        do_load_exp(32'h4, 2'd2, 1'b0, 32'hCD112233, "sh.w1");
        do_load_exp(32'h8, 2'd2, 1'b0, 32'h000000AB, "sh.w2");

        // Wrap and alias.
        sw(32'h1000, 32'hCAFEF00D, "sw_alias");
        do_load_exp(32'h0, 2'd2, 1'b0, 32'hCAFEF00D, "lw_alias");
        do_load(32'hFFF, 2'd1, 1'b0, "lh_wrap");
        do_store(32'hFFE, 32'h5A6B7C8D, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, "sw_wrap");
        do_load(32'hFFE, 2'd2, 1'b0, "lw_wrap");

        // Reset during the first write cycle of a crossing store.
        sw(32'h4, 32'h55667788, "pre_rst");
        addr_i      = 32'h3;
        wdata_i     = 32'h99AABBCC;
        mem_acc_w_i = 2'd2;
        mem_wr_en_i = 1'b1;
        tick();
        mem_wr_en_i = 1'b0;
        check("mr.busy_wr1", 32'(busy_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("mr.busy", 32'(busy_o), 32'd0);
        check("mr.ready", 32'(mem_wr_ready_o), 32'd0);
        check("mr.rdata", rdata_o, 32'h0);
        #2;
        rstn_i = 1'b1;
        tick();
        check("mr.busy2", 32'(busy_o), 32'd0);
        check("mr.ready2", 32'(mem_wr_ready_o), 32'd0);
        sw(32'h0, 32'h0BADF00D, "post_rst");
        do_load_exp(32'h4, 2'd2, 1'b0, 32'h55667788, "mr.w1");
        do_load(32'h0, 2'd2, 1'b0, "mr.w0");

        // Randomized traffic inside the initialised window, with aliasing.
        for (int t = 0; t < 300; t++) begin
            widx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 14))
                                               : int'($urandom_range(1008, 1023));
            a = $urandom();
            a[11:2] = 10'(widx);
            op = int'($urandom_range(0, 2));
            if (op == 0) begin
                do_load(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        $sformatf("rl%0d", t));
            end else begin
                do_store(a, $urandom(), 2'($urandom_range(0, 3)), op == 2,
                         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), $sformatf("rs%0d", t));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
